// File: rtl/t05_hist_engine.sv
`default_nettype none
// ============================================================================
// Module   : t05_hist_engine
// Brief    : Symbol histogram engine; read-modify-write of SRAM bin counts,
//            EOF detection and a full bin-clear sweep.
//            Optional macro T05_HIST_SAT_EN: saturating bin and total counts.
// Revision : 1.0 - initial release
// ============================================================================
module t05_hist_engine #(
    parameter int               SYM_W   = 8,
    parameter int               CNT_W   = 32,
    parameter logic [SYM_W-1:0] EOF_SYM = SYM_W'(8'h1A)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    input  logic             clear_start,
    output logic             mem_req,
    output logic             mem_we,
    output logic [SYM_W-1:0] mem_addr,
    output logic [CNT_W-1:0] mem_wdata,
    input  logic [CNT_W-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             eof,
    output logic             complete,
    output logic             busy,
    output logic [CNT_W-1:0] total
);

    localparam logic [2:0]       c_IDLE      = 3'd0;
    localparam logic [2:0]       c_RD        = 3'd1;
    localparam logic [2:0]       c_WR        = 3'd2;
    localparam logic [2:0]       c_DONE      = 3'd3;
    localparam logic [2:0]       c_CLR       = 3'd4;
    localparam logic [SYM_W-1:0] c_LAST_ADDR = '1;
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    logic [2:0]       r_state;
    logic             r_ready;
    logic             r_req;
    logic             r_we;
    logic [SYM_W-1:0] r_addr;
    logic [CNT_W-1:0] r_wdata;
    logic             r_eof;
    logic             r_complete;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] w_bin_inc;
    logic [CNT_W-1:0] w_total_inc;

`ifdef T05_HIST_SAT_EN
    assign w_bin_inc   = (&mem_rdata) ? mem_rdata : mem_rdata + c_ONE;
    assign w_total_inc = (&r_total)   ? r_total   : r_total + c_ONE;
`else
    assign w_bin_inc   = mem_rdata + c_ONE;
    assign w_total_inc = r_total + c_ONE;
`endif

    // A pending clear wins over a symbol offered in the same IDLE cycle.
    assign sym_ready = r_ready && !clear_start;
    assign busy      = (r_state != c_IDLE) && (r_state != c_DONE);
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign eof       = r_eof;
    assign complete  = r_complete;
    assign total     = r_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_ready    <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_eof      <= 1'b0;
            r_complete <= 1'b0;
            r_total    <= '0;
        end else begin
            r_eof <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_ready <= 1'b1;
                    if (clear_start) begin
                        r_state <= c_CLR;
                        r_ready <= 1'b0;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= '0;
                    end else if (sym_valid && r_ready) begin
                        r_ready <= 1'b0;
                        if (sym_data == EOF_SYM) begin
                            r_state <= c_DONE;
                            r_eof   <= 1'b1;
                        end else begin
                            r_state <= c_RD;
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_addr  <= sym_data;
                        end
                    end
                end
                c_RD: begin
                    if (mem_ack) begin
                        r_state <= c_WR;
                        r_we    <= 1'b1;
                        r_wdata <= w_bin_inc;
                    end
                end
                c_WR: begin
                    if (mem_ack) begin
                        r_state <= c_IDLE;
                        r_ready <= 1'b1;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_total <= w_total_inc;
                    end
                end
                c_DONE: begin
                    r_complete <= 1'b1;
                    if (clear_start) begin
                        r_state <= c_CLR;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= '0;
                    end
                end
                c_CLR: begin
                    if (mem_ack) begin
                        if (r_addr == c_LAST_ADDR) begin
                            // Results stay visible until the sweep has really finished.
                            r_state    <= c_IDLE;
                            r_ready    <= 1'b1;
                            r_req      <= 1'b0;
                            r_we       <= 1'b0;
                            r_total    <= '0;
                            r_complete <= 1'b0;
                        end else begin
                            r_addr <= r_addr + SYM_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_ready <= 1'b0;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t05_hist_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_t05_hist_engine
// Brief    : Directed self-checking bench for t05_hist_engine with an SRAM
//            model that acknowledges after a programmable number of cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t05_hist_engine;

    logic        clk;
    logic        rst;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        sym_ready;
    logic        clear_start;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        eof;
    logic        complete;
    logic        busy;
    logic [31:0] total;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [31:0] mem [256];
    int          ack_dly;
    int          wcnt;
    logic        clr_mon;
    int          clr_writes;
    int          clr_bad;
    logic        stab_en;
    logic        stab_pend;
    logic [7:0]  stab_addr;
    logic        stab_we;
    logic [31:0] stab_wdata;

    t05_hist_engine dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .clear_start(clear_start),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .eof        (eof),
        .complete   (complete),
        .busy       (busy),
        .total      (total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM model: ack arrives ack_dly cycles after the request starts.
    assign mem_ack   = mem_req && (wcnt >= ack_dly);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
        if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            if (clr_mon) begin
                if (mem_addr != clr_writes[7:0] || mem_wdata != 32'd0) clr_bad <= clr_bad + 1;
                clr_writes <= clr_writes + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (stab_en) begin
            if (stab_pend && mem_req) begin
                chk("stable_addr", mem_addr, stab_addr);
                chk("stable_we", mem_we, stab_we);
                chk("stable_wdata", mem_wdata, stab_wdata);
            end
            stab_pend  = mem_req && !mem_ack;
            stab_addr  = mem_addr;
            stab_we    = mem_we;
            stab_wdata = mem_wdata;
        end else begin
            stab_pend = 1'b0;
        end
    end

    task automatic send(input logic [7:0] s, input string tag);
        int n;
        sym_valid = 1'b1;
        sym_data  = s;
        n = 0;
        while (!sym_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, "_accept_timeout"}, 1, 0);
        @(negedge clk);
        sym_valid = 1'b0;
        n = 0;
        while (!sym_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_idle_timeout"}, 1, 0);
    endtask

    initial begin
        int n;
        logic [31:0] exp_sat;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h41] = 32'd5;
        mem[8'h80] = 32'hFFFF_FFFF;
        ack_dly = 0; wcnt = 0;
        clr_mon = 1'b0; clr_writes = 0; clr_bad = 0;
        stab_en = 1'b0;
        rst = 1'b1; sym_valid = 1'b0; sym_data = 8'h00; clear_start = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", sym_ready, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_eof_complete_busy", {eof, complete, busy}, 0);
        chk("rst_total", total, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", sym_ready, 1);

        // Single symbol with zero-wait SRAM
        sym_valid = 1'b1; sym_data = 8'h41;
        @(negedge clk);
        sym_valid = 1'b0;
        chk("t1_rd_req", {mem_req, mem_we}, 2'b10);
        chk("t1_rd_addr", mem_addr, 8'h41);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_wr_req", {mem_req, mem_we}, 2'b11);
        chk("t1_wr_data", mem_wdata, 32'd6);
        @(negedge clk);
        chk("t1_ready_back", sym_ready, 1);
        chk("t1_bin", mem[8'h41], 32'd6);
        chk("t1_total", total, 1);
        chk("t1_req_idle", mem_req, 0);

        // Ready-low window length for a zero-wait symbol
        sym_valid = 1'b1; sym_data = 8'h30;
        @(negedge clk);
        sym_valid = 1'b0;
        n = 0;
        while (!sym_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("t1_ready_low_cycles", n, 2);
        chk("t1_total2", total, 2);

        // Delayed acks with stability monitoring
        ack_dly = 2;
        stab_en = 1'b1;
        send(8'h41, "t2_a");
        send(8'h42, "t2_b");
        send(8'h41, "t2_c");
        stab_en = 1'b0;
        chk("t2_bin41", mem[8'h41], 32'd8);
        chk("t2_bin42", mem[8'h42], 32'd1);
        chk("t2_total", total, 5);

        // EOF symbol
        ack_dly = 0;
        sym_valid = 1'b1; sym_data = 8'h1A;
        chk("t3_ready_pre", sym_ready, 1);
        @(negedge clk);
        chk("t3_eof_pulse", eof, 1);
        chk("t3_complete_early", complete, 0);
        chk("t3_ready_bp", sym_ready, 0);
        chk("t3_total", total, 5);
        @(negedge clk);
        chk("t3_eof_gone", eof, 0);
        chk("t3_complete", complete, 1);
        chk("t3_ready_bp2", sym_ready, 0);
        @(negedge clk);
        chk("t3_complete_held", complete, 1);
        chk("t3_busy", busy, 0);
        sym_valid = 1'b0;

        // Clear sweep from DONE
        clr_mon = 1'b1;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        chk("t4_busy", busy, 1);
        chk("t4_total_kept", total, 5);
        chk("t4_complete_kept", complete, 1);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("t4_sweep_timeout", 1, 0);
        clr_mon = 1'b0;
        chk("t4_write_count", clr_writes, 256);
        chk("t4_order_bad", clr_bad, 0);
        chk("t4_total", total, 0);
        chk("t4_complete", complete, 0);
        chk("t4_ready", sym_ready, 1);
        chk("t4_bin41", mem[8'h41], 0);
        mem[8'h80] = 32'hFFFF_FFFF;

        // All-ones bin
`ifdef T05_HIST_SAT_EN
        exp_sat = 32'hFFFF_FFFF;
`else
        exp_sat = 32'h0000_0000;
`endif
        send(8'h80, "t5");
        chk("t5_bin_ones", mem[8'h80], exp_sat);
        chk("t5_total", total, 1);

        // Reset during RD with ack withheld
        ack_dly = 100;
        sym_valid = 1'b1; sym_data = 8'h10;
        @(negedge clk);
        sym_valid = 1'b0;
        chk("t6_rd_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_req_drop", mem_req, 0);
        chk("t6_ready", sym_ready, 0);
        chk("t6_total", total, 0);
        chk("t6_addr", mem_addr, 0);
        chk("t6_busy", busy, 0);
        @(negedge clk);
        chk("t6_ready_after", sym_ready, 1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
